// File: rtl/dla_walk_ctrl_if.sv
// dla_walk_ctrl_if: particle-checker handshake and VRAM Avalon-MM write bus of the DLA walker
interface dla_walk_ctrl_if #(
  parameter int H_SIZE = 10,
  parameter int V_SIZE = 9,
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16
);
  logic [H_SIZE-1:0] check_x;
  logic [V_SIZE-1:0] check_y;
  logic check_start;
  logic check_done;
  logic hit_boundary;
  logic hit_neighbor;
  logic [AVN_AW-1:0] vram_avn_address;
  logic vram_avn_write;
  logic [AVN_DW-1:0] vram_avn_writedata;
  logic vram_avn_waitrequest;
  modport master (
    output check_x, check_y, check_start, vram_avn_address, vram_avn_write, vram_avn_writedata,
    input check_done, hit_boundary, hit_neighbor, vram_avn_waitrequest
  );
  modport slave (
    input check_x, check_y, check_start, vram_avn_address, vram_avn_write, vram_avn_writedata,
    output check_done, hit_boundary, hit_neighbor, vram_avn_waitrequest
  );
endinterface

// File: rtl/dla_walk_ctrl.sv
// dla_walk_ctrl: diffusion-limited-aggregation walker; spawns, walks and sticks particles into VRAM
module dla_walk_ctrl #(
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16,
  parameter int MAX_PARTICLES = 1024,
  parameter int MAX_STEPS = 4096,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int H_SIZE = $clog2(H_DISPLAY),
  parameter int V_SIZE = $clog2(V_DISPLAY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [15:0] particle_count,
  dla_walk_ctrl_if.master bus
);
  localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  typedef enum logic [7:0] {
    IDLE    = 8'h01,
    SEED_WR = 8'h02,
    SPAWN   = 8'h04,
    CHECK   = 8'h08,
    WAIT    = 8'h10,
    STEP    = 8'h20,
    WRITE   = 8'h40,
    DONE    = 8'h80
  } state_t;
  state_t state, state_nxt;
  logic [15:0] lfsr;
  logic [H_SIZE-1:0] pos_x, cand_x;
  logic [V_SIZE-1:0] pos_y, cand_y;
  logic [SW-1:0] step_cnt;
  logic [15:0] cnt_inc;
  logic cand_ok, wr_state, wr_acc, last, step_last;
  assign cand_x = lfsr[H_SIZE-1:0];
  assign cand_y = lfsr[15 -: V_SIZE];
  assign cand_ok = cand_x != '0 && cand_x <= H_SIZE'(H_DISPLAY - 2) &&
                   cand_y != '0 && cand_y <= V_SIZE'(V_DISPLAY - 2);
  assign wr_state = state == SEED_WR || state == WRITE;
  assign wr_acc = wr_state && !bus.vram_avn_waitrequest;
  assign cnt_inc = particle_count + 16'd1;
  assign last = cnt_inc == 16'(MAX_PARTICLES);
  assign step_last = step_cnt == SW'(MAX_STEPS - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus.check_start = state == CHECK;
  assign bus.check_x = pos_x;
  assign bus.check_y = pos_y;
  assign bus.vram_avn_write = wr_state;
  // Address and data are gated so the bus idles at zero outside a write.
  assign bus.vram_avn_address = wr_state ?
    AVN_AW'(pos_x) + AVN_AW'(pos_y) * AVN_AW'(H_DISPLAY) : '0;
  assign bus.vram_avn_writedata = wr_state ? {AVN_DW{1'b1}} : '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           state_nxt = start ? SEED_WR : IDLE;
      SEED_WR, WRITE: state_nxt = !wr_acc ? state : last ? DONE : SPAWN;
      SPAWN:          state_nxt = cand_ok ? CHECK : SPAWN;
      CHECK:          state_nxt = WAIT;
      WAIT:           state_nxt = !bus.check_done ? WAIT : bus.hit_boundary ? SPAWN :
                                  bus.hit_neighbor ? WRITE : step_last ? SPAWN : STEP;
      STEP:           state_nxt = CHECK;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr <= SEED;
      pos_x <= '0;
      pos_y <= '0;
      step_cnt <= '0;
      particle_count <= '0;
    end else begin
      state <= state_nxt;
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (state == IDLE && start) begin
        particle_count <= '0;
        pos_x <= H_SIZE'(H_DISPLAY / 2);
        pos_y <= V_SIZE'(V_DISPLAY / 2);
      end
      if (wr_acc) particle_count <= cnt_inc;
      if (state == SPAWN && cand_ok) begin
        pos_x <= cand_x;
        pos_y <= cand_y;
        step_cnt <= '0;
      end
      // Direction lfsr[1:0]: 0 x+1, 1 x-1, 2 y+1, 3 y-1; wraps silently, checker flags it.
      if (state == STEP) begin
        pos_x <= lfsr[1] ? pos_x : lfsr[0] ? pos_x - 1'b1 : pos_x + 1'b1;
        pos_y <= !lfsr[1] ? pos_y : lfsr[0] ? pos_y - 1'b1 : pos_y + 1'b1;
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/dla_walk_ctrl.md
DLA_WALK_CTRL -- requirements
Module: dla_walk_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AVN_AW, 19, VRAM address width.
- AVN_DW, 16, VRAM data width.
- MAX_PARTICLES, 1024, number of stuck particles that ends a run.
- MAX_STEPS, 4096, walk steps before a particle is discarded.
- SEED, 16'hACE1, LFSR reset value (non-zero).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, run request; sampled in IDLE only.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when the run completes.
- particle_count, out, 16, stuck particles including the seed.
- check_x, out, H_SIZE, position under check.
- check_y, out, V_SIZE, position under check.
- check_start, out, 1, one-cycle pulse to the particle checker.
- check_done, in, 1, checker result valid.
- hit_boundary, in, 1, checker result.
- hit_neighbor, in, 1, checker result.
- vram_avn_address, out, AVN_AW, Avalon-MM write address.
- vram_avn_write, out, 1, Avalon-MM write.
- vram_avn_writedata, out, AVN_DW, Avalon-MM write data.
- vram_avn_waitrequest, in, 1, Avalon-MM wait request.

Function
REQ-004 The state machine SHALL be one-hot with states IDLE, SEED_WR, SPAWN, CHECK, WAIT, STEP, WRITE and DONE.
REQ-005 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle in every state.
REQ-006 IDLE SHALL do the following:
- start=1 -> SEED_WR.
- particle_count cleared to 0.
- Position registers loaded with (H_DISPLAY/2, V_DISPLAY/2).
REQ-007 In SEED_WR and WRITE, the block SHALL drive the write as follows:
- vram_avn_write=1.
- address = {zero-ext x} + y*H_DISPLAY.
- writedata = all ones.
- All three held stable until a cycle with waitrequest=0.
- The write is accepted on that cycle.
REQ-008 On write acceptance, particle_count SHALL increment by 1; the next state SHALL be DONE if the new count equals MAX_PARTICLES, otherwise SPAWN.
REQ-009 SPAWN SHALL handle each cycle's candidate as follows:
- Candidate x = lfsr[H_SIZE-1:0], y = lfsr[15 -: V_SIZE].
- Accept only if 1<=x<=H_DISPLAY-2 and 1<=y<=V_DISPLAY-2.
- On accept: latch x and y, clear step_cnt, go to CHECK.
- Otherwise: stay in SPAWN (rejection sampling).
REQ-010 CHECK SHALL assert check_start for exactly one cycle, then go to WAIT; check_x/check_y SHALL be driven from the position registers and held stable from CHECK through WAIT.
REQ-011 WAIT SHALL hold until check_done=1, then branch by priority:
- hit_boundary -> SPAWN (particle discarded).
- else hit_neighbor -> WRITE.
- else step_cnt==MAX_STEPS-1 -> SPAWN (discarded).
- else -> STEP.
REQ-012 STEP SHALL move the particle by direction lfsr[1:0] (0: x+1, 1: x-1, 2: y+1, 3: y-1), increment step_cnt, and go to CHECK in one cycle.
REQ-013 STEP arithmetic SHALL be modulo field width with no clamping; any out-of-range result is caught by the checker's boundary report on the next check.
REQ-014 DONE SHALL assert done for one cycle, then go to IDLE; particle_count SHALL hold its value until the next start.
REQ-015 start asserted in any state other than IDLE SHALL be ignored.
REQ-016 check_done received outside WAIT SHALL be ignored.
REQ-017 vram_avn_write SHALL never be asserted in the same cycle as check_start.
REQ-018 The address multiply SHALL be computed at AVN_AW width; for 640x480 the maximum address is 307199.

Reset
REQ-019 While rst_n=0, regardless of the cycle:
- state=IDLE; lfsr=SEED; position=0; step_cnt=0; particle_count=0.
- busy=0, done=0, check_start=0, vram_avn_write=0.
- vram_avn_address=0, vram_avn_writedata=0.
REQ-020 Reset asserted mid-write or mid-check SHALL abandon the operation; no write SHALL be issued after rst_n deasserts until a new start.

Verification
REQ-021 The bench SHALL cover these directed scenarios (640x480 display):
- Seed write: start, waitrequest held 3 cycles -> write held 4 cycles at address 153920 with data 16'hFFFF; count=1.
- Boundary discard: checker returns hit_boundary -> next state SPAWN; no write; count unchanged.
- Neighbor stick: checker returns hit_neighbor at (100,50) -> one write to address 32100; count increments.
- Step limit: MAX_STEPS=4 with checker always clear -> exactly 4 check_start pulses, then SPAWN.
- Completion: MAX_PARTICLES=3 with checker always hit_neighbor -> exactly 3 writes, one done pulse, busy low the next cycle.
- Reset in WAIT, plus start during busy -> all outputs at reset values and the start is ignored.
